// File: rtl/stage3_pow2_approx.sv
// ---------------------------------------------------------------------------
// stage3_pow2_approx
//   Stage 3 of the softmax approximation pipeline. Computes y ~= 2^x for a
//   signed Q4.12 exponent using the linear-mantissa (Mitchell) method:
//     x = i + f, i = floor(x) (signed top nibble), f = fraction in [0,1)
//     y = (1 + f) * 2^i
//   The result is registered together with a valid flag, and the input word is
//   forwarded alongside the result for use by later stages.
//
// Configuration macro:
//   POW2_ROUND_EN - when defined, negative-exponent right shifts round half-up
//                   (the bit just below the kept LSB is added back). When
//                   undefined (default) right shifts truncate toward zero.
//
// Ports:
//   clk          in   1        rising-edge clock
//   rst          in   1        asynchronous active-low reset
//   en           in   1        stage enable; 0 holds every register
//   valid_in     in   1        in_x is valid this cycle
//   in_x         in   DATA_W   signed Q4.12 exponent x (-8.0 .. +7.99976)
//   valid_out    out  1        pow_in_x / in_x_bypass are valid
//   pow_in_x     out  DATA_W   Q4.12 result 2^x, never negative, never zero
//   in_x_bypass  out  DATA_W   registered copy of the x that produced pow_in_x
// ---------------------------------------------------------------------------
module stage3_pow2_approx #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] in_x,
  output logic              valid_out,
  output logic [DATA_W-1:0] pow_in_x,
  output logic [DATA_W-1:0] in_x_bypass
);

  // Largest representable positive Q4.12 value, used when 2^x would not fit.
  localparam logic [15:0] SAT_VALUE = 16'h7FFF;

  // 2^x approximation for one Q4.12 word.
  // For i in 0..2 the 13-bit mantissa shifted left by at most 2 occupies at
  // most 15 bits, so bit 15 can never be set; i >= 3 saturates instead of
  // shifting. For i < 0 the shift distance is 1..8, so the result is at
  // least 0x1000 >> 8 = 0x0010 and never reaches zero.
  function automatic logic [15:0] pow2_approx(input logic [15:0] x);
    logic signed [3:0] exp_i;
    logic [12:0]       mant;
    logic [14:0]       left_val;
    logic [3:0]        rsh;
    logic [12:0]       pre_shift;
    logic [12:0]       trunc_val;
    logic              round_bit;
    logic [12:0]       right_val;
    logic [15:0]       result;

    exp_i     = signed'(x[15:12]);
    mant      = {1'b1, x[11:0]};
    left_val  = {2'b00, mant} << exp_i[1:0];
    // Two's-complement negate of the exponent; i = -8 yields 4'd8 as wanted.
    rsh       = 4'd0 - x[15:12];
    // Shift one position short so the bit just below the kept LSB is exposed
    // as pre_shift[0]; it is only consumed when rounding is compiled in.
    pre_shift = mant >> (rsh - 4'd1);
    trunc_val = pre_shift >> 1;
    round_bit = pre_shift[0];
`ifdef POW2_ROUND_EN
    // Cannot overflow: trunc_val <= 0x0FFF whenever i < 0.
    right_val = trunc_val + {12'd0, round_bit};
`else
    right_val = trunc_val | {12'd0, 1'b0 & round_bit};
`endif

    if (exp_i[3]) begin
      result = {3'b000, right_val};
    end else if (exp_i >= 4'sd3) begin
      result = SAT_VALUE;
    end else begin
      result = {1'b0, left_val};
    end
    return result;
  endfunction

  logic              valid_d;
  logic              valid_q;
  logic [DATA_W-1:0] pow_d;
  logic [DATA_W-1:0] pow_q;
  logic [DATA_W-1:0] bypass_d;
  logic [DATA_W-1:0] bypass_q;
  logic [DATA_W-1:0] pow_calc_s;

  // Arithmetic on the raw input; only registered when a valid sample is taken.
  always_comb begin
    pow_calc_s = pow2_approx(in_x);
  end

  // Next-state selection: en gates everything, valid_in gates the data words.
  always_comb begin
    valid_d  = valid_q;
    pow_d    = pow_q;
    bypass_d = bypass_q;
    if (en) begin
      valid_d = valid_in;
      if (valid_in) begin
        pow_d    = pow_calc_s;
        bypass_d = in_x;
      end else begin
        pow_d    = pow_q;
        bypass_d = bypass_q;
      end
    end else begin
      valid_d  = valid_q;
      pow_d    = pow_q;
      bypass_d = bypass_q;
    end
  end

  // Output registers; asynchronous reset clears a pending result immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      pow_q    <= 16'h0000;
      bypass_q <= 16'h0000;
    end else begin
      valid_q  <= valid_d;
      pow_q    <= pow_d;
      bypass_q <= bypass_d;
    end
  end

  assign valid_out   = valid_q;
  assign pow_in_x    = pow_q;
  assign in_x_bypass = bypass_q;

endmodule

// File: tb/tb_stage3_pow2_approx.sv
// ---------------------------------------------------------------------------
// tb_stage3_pow2_approx
//   Directed bench for stage3_pow2_approx. Stimulus pushes hand-computed
//   expected results into a scoreboard queue; an independent monitor pops and
//   compares whenever valid_out is seen high on a falling clock edge.
// ---------------------------------------------------------------------------
module tb_stage3_pow2_approx;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        en;
  logic        valid_in;
  logic [15:0] in_x;
  logic        valid_out;
  logic [15:0] pow_in_x;
  logic [15:0] in_x_bypass;

  exp_t sb_q[$];
  int   n_checks;
  int   n_fail;

  stage3_pow2_approx dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .valid_in   (valid_in),
    .in_x       (in_x),
    .valid_out  (valid_out),
    .pow_in_x   (pow_in_x),
    .in_x_bypass(in_x_bypass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every valid output must match the oldest pending entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && valid_out === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got valid_out=1 expected 0 (queue empty) at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        check16("pow_in_x", pow_in_x, e.y);
        check16("in_x_bypass", in_x_bypass, e.x);
      end
    end
  end

  task automatic send(input logic [15:0] x, input logic [15:0] y);
    exp_t e;
    @(posedge clk);
    #1;
    valid_in = 1'b1;
    in_x     = x;
    e.x = x;
    e.y = y;
    sb_q.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    in_x     = 16'hDEAD;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending results expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  logic [15:0] vec_x [0:10];
  logic [15:0] vec_y [0:10];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    en       = 1'b0;
    valid_in = 1'b0;
    in_x     = 16'h0000;

    vec_x[0]  = 16'hC000; vec_y[0]  = 16'h0100;
    vec_x[1]  = 16'hF800; vec_y[1]  = 16'h0C00;
    vec_x[2]  = 16'hFC00; vec_y[2]  = 16'h0E00;
    vec_x[3]  = 16'h0000; vec_y[3]  = 16'h1000;
    vec_x[4]  = 16'h0800; vec_y[4]  = 16'h1800;
    vec_x[5]  = 16'h2000; vec_y[5]  = 16'h4000;
    vec_x[6]  = 16'h2800; vec_y[6]  = 16'h6000;
    vec_x[7]  = 16'h2E00; vec_y[7]  = 16'h7800;
    vec_x[8]  = 16'h8000; vec_y[8]  = 16'h0010;
    vec_x[9]  = 16'h3000; vec_y[9]  = 16'h7FFF;
    vec_x[10] = 16'h7FFF; vec_y[10] = 16'h7FFF;

    // Reset held with clocks running
    repeat (3) @(negedge clk);
    check16("rst_valid_out", {15'd0, valid_out}, 16'h0000);
    check16("rst_pow_in_x", pow_in_x, 16'h0000);
    check16("rst_in_x_bypass", in_x_bypass, 16'h0000);

    @(posedge clk);
    #1;
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) @(negedge clk);
    check16("idle_valid_out", {15'd0, valid_out}, 16'h0000);
    check16("idle_pow_in_x", pow_in_x, 16'h0000);

    // Single-cycle pulse, then data must hold with valid low
    send(16'hC000, 16'h0100);
    idle();
    repeat (2) @(posedge clk);
    #1;
    check16("pulse_valid_low", {15'd0, valid_out}, 16'h0000);
    check16("pulse_pow_held", pow_in_x, 16'h0100);
    check16("pulse_bypass_held", in_x_bypass, 16'hC000);

    // Back-to-back basic points and boundaries
    for (int i = 0; i < 11; i++) begin
      send(vec_x[i], vec_y[i]);
    end
`ifdef POW2_ROUND_EN
    send(16'h8FFF, 16'h0020);
`else
    send(16'h8FFF, 16'h001F);
`endif
    idle();
    drain();

    // en = 0 with valid_in = 1: nothing may change
    @(posedge clk);
    #1;
    en       = 1'b0;
    valid_in = 1'b1;
    in_x     = 16'h0800;
    repeat (3) @(posedge clk);
    #1;
    check16("en0_valid_out", {15'd0, valid_out}, 16'h0000);
`ifdef POW2_ROUND_EN
    check16("en0_pow_held", pow_in_x, 16'h0020);
`else
    check16("en0_pow_held", pow_in_x, 16'h001F);
`endif
    check16("en0_bypass_held", in_x_bypass, 16'h8FFF);
    valid_in = 1'b0;
    en       = 1'b1;

    // Reset asserted while a result is presented
    send(16'h2000, 16'h4000);
    @(posedge clk);
    #2;
    valid_in = 1'b0;
    check16("mid_valid_before_rst", {15'd0, valid_out}, 16'h0001);
    rst = 1'b0;
    #1;
    check16("mid_rst_valid_out", {15'd0, valid_out}, 16'h0000);
    check16("mid_rst_pow_in_x", pow_in_x, 16'h0000);
    check16("mid_rst_in_x_bypass", in_x_bypass, 16'h0000);
    sb_q.delete();
    @(posedge clk);
    #3;
    rst = 1'b1;

    // First sample after reset release is captured normally
    send(16'h0800, 16'h1800);
    idle();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
